// File: rtl/barrier_damage_ctrl.sv
// Barrier damage controller: keeps a 128-cell health map for the four player
// barriers. It arbitrates bullet hits from two requesters and erodes the cells
// they land on. It answers per-pixel draw queries and refills every cell on
// reset or on a new-wave restore.
module barrier_damage_ctrl #(
   parameter int SPRITE_ROW    = 380,
   parameter int SPRITE_COL    = 40,
   parameter int BARRIER_PITCH = 120,
   parameter int MAX_HEALTH    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] pixel_row,
   input  logic [11:0] pixel_column,
   output logic        barrier_mask,
   output logic [1:0]  barrier_health,
   input  logic [1:0]  hit_valid,
   input  logic [23:0] hit_row,
   input  logic [23:0] hit_col,
   output logic [1:0]  hit_ready,
   output logic        resp_valid,
   output logic        resp_id,
   output logic        resp_absorbed,
   input  logic        restore,
   output logic        busy
);

   typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, DECODE = 2'd2, UPDATE = 2'd3} state_t;

   // Returns {inside_footprint, barrier[1:0], cell_row[1:0], cell_col[2:0]}.
   // The column-within-cell uses a compare chain instead of a divide-by-5.
   function automatic logic [7:0] locate(input logic [11:0] row, input logic [11:0] col);
      logic        in_rows;
      logic        in_cols;
      logic [1:0]  bar;
      logic [1:0]  cell_row;
      logic [2:0]  cell_col;
      logic [11:0] c;
      in_rows  = (row >= 12'(SPRITE_ROW + 1)) && (row <= 12'(SPRITE_ROW + 32));
      cell_row = 2'((row - 12'(SPRITE_ROW + 1)) >> 3);
      in_cols  = 1'b0;
      bar      = 2'd0;
      c        = 12'd0;
      for (int i = 0; i < 4; i++) begin
         if ((col >= 12'(SPRITE_COL + 1 + BARRIER_PITCH * i)) &&
             (col <= 12'(SPRITE_COL + 40 + BARRIER_PITCH * i))) begin
            in_cols = 1'b1;
            bar     = 2'(i);
            c       = col - 12'(SPRITE_COL + 1 + BARRIER_PITCH * i);
         end
      end
      if      (c < 12'd5)  cell_col = 3'd0;
      else if (c < 12'd10) cell_col = 3'd1;
      else if (c < 12'd15) cell_col = 3'd2;
      else if (c < 12'd20) cell_col = 3'd3;
      else if (c < 12'd25) cell_col = 3'd4;
      else if (c < 12'd30) cell_col = 3'd5;
      else if (c < 12'd35) cell_col = 3'd6;
      else                 cell_col = 3'd7;
      return {in_rows & in_cols, bar, cell_row, cell_col};
   endfunction

   logic [1:0]  health_mem [128];

   state_t      state_reg, state_next;
   logic [6:0]  count_reg;
   logic        last_reg;      // requester served most recently
   logic        sel_reg;       // requester of the hit in flight
   logic        pending_reg;   // restore seen while a hit was in flight
   logic [11:0] row_reg, col_reg;
   logic [7:0]  loc_reg;

   logic        grant_id;
   logic        mem_we;
   logic [6:0]  mem_waddr;
   logic [1:0]  mem_wdata;
   logic [1:0]  upd_health;
   logic        absorb;
   logic [7:0]  q_loc;
   logic [1:0]  q_health;

   assign grant_id   = (hit_valid == 2'b11) ? ~last_reg : hit_valid[1];
   assign upd_health = health_mem[loc_reg[6:0]];
   assign absorb     = (state_reg == UPDATE) && loc_reg[7] && (upd_health != 2'd0);
   assign q_loc      = locate(pixel_row, pixel_column);
   assign q_health   = health_mem[q_loc[6:0]];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= INIT;
      else      state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         INIT:    if (!restore && count_reg == 7'd127) state_next = IDLE;
         IDLE:    if (restore) state_next = INIT;
                  else if (|hit_valid) state_next = DECODE;
         DECODE:  state_next = UPDATE;
         UPDATE:  state_next = (restore || pending_reg) ? INIT : IDLE;
         default: state_next = INIT;
      endcase
   end

   // Outputs and write port selection per state
   always_comb begin
      hit_ready = 2'b00;
      mem_we    = 1'b0;
      mem_waddr = count_reg;
      mem_wdata = 2'(MAX_HEALTH);
      case (state_reg)
         INIT:    mem_we = !restore;
         IDLE:    if (!restore && |hit_valid) hit_ready = grant_id ? 2'b10 : 2'b01;
         UPDATE:  if (absorb) begin
                     mem_we    = 1'b1;
                     mem_waddr = loc_reg[6:0];
                     mem_wdata = upd_health - 2'd1;
                  end
         default: ;
      endcase
   end

   // Sweep counter, hit capture, decode pipeline and response strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg     <= 7'd0;
         busy          <= 1'b1;
         last_reg      <= 1'b1;
         sel_reg       <= 1'b0;
         pending_reg   <= 1'b0;
         row_reg       <= 12'd0;
         col_reg       <= 12'd0;
         loc_reg       <= 8'd0;
         resp_valid    <= 1'b0;
         resp_id       <= 1'b0;
         resp_absorbed <= 1'b0;
      end else begin
         resp_valid    <= (state_reg == UPDATE);
         resp_id       <= (state_reg == UPDATE) && sel_reg;
         resp_absorbed <= absorb;
         if (state_next == INIT && state_reg != INIT) begin
            count_reg   <= 7'd0;
            busy        <= 1'b1;
            pending_reg <= 1'b0;
         end
         case (state_reg)
            INIT: begin
               if (restore) begin
                  count_reg <= 7'd0;
               end else begin
                  count_reg <= count_reg + 7'd1;
                  if (count_reg == 7'd127) busy <= 1'b0;
               end
            end
            IDLE: begin
               if (!restore && |hit_valid) begin
                  sel_reg  <= grant_id;
                  last_reg <= grant_id;
                  row_reg  <= grant_id ? hit_row[23:12] : hit_row[11:0];
                  col_reg  <= grant_id ? hit_col[23:12] : hit_col[11:0];
               end
            end
            DECODE: begin
               loc_reg <= locate(row_reg, col_reg);
               if (restore) pending_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Health map write port (no reset: the INIT sweep defines contents)
   always_ff @(posedge clk) begin
      if (mem_we) health_mem[mem_waddr] <= mem_wdata;
   end

   // Pixel query: combinational lookup, registered result (old data on collision)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         barrier_mask   <= 1'b0;
         barrier_health <= 2'd0;
      end else begin
         barrier_mask   <= q_loc[7] && (q_health != 2'd0);
         barrier_health <= q_loc[7] ? q_health : 2'd0;
      end
   end

endmodule

// File: doc/barrier_damage_ctrl.md
Name: barrier_damage_ctrl

Overview:
Tracks erosion of the four player barriers in the space-invaders VGA peripheral. Bullet-collision hits arrive from two requesters, the player shot and the alien shot. The block arbitrates between them, decrements per-cell health and reports whether each bullet was absorbed. It also answers per-pixel draw queries for the VGA colour mux, and restores all barriers on a new-wave request.

Parameters:
SPRITE_ROW, 380, top edge; footprint rows SPRITE_ROW+1..SPRITE_ROW+32
SPRITE_COL, 40, left edge of barrier 0; footprint cols SPRITE_COL+1+120*b..SPRITE_COL+40+120*b, b=0..3
BARRIER_PITCH, 120, column offset between barriers
MAX_HEALTH, 3, cell health after restore (2-bit)

Ports:
clk  in  1  pixel/system clock
rst  in  1  reset: asynchronous, active-low
pixel_row  in  12  current VGA row
pixel_column  in  12  current VGA column
barrier_mask  out  1  registered: pixel lies in an intact cell
barrier_health  out  2  registered: health of that cell (0 outside)
hit_valid  in  2  [0]=player shot, [1]=alien shot; held until accepted
hit_row  in  24  {req1,req0} 12-bit collision row
hit_col  in  24  {req1,req0} 12-bit collision column
hit_ready  out  2  one-cycle accept strobe per requester
resp_valid  out  1  one-cycle result strobe
resp_id  out  1  requester served
resp_absorbed  out  1  1 = cell was intact and is now decremented
restore  in  1  pulse: refill all cells to MAX_HEALTH
busy  out  1  high during restore sweep

Behaviour:
- Cell map: 4 barriers x 4 cell-rows x 8 cell-cols = 128 cells, 2 bits each. Cell = 8 rows x 5 cols.
- Local coordinates: r = row-(SPRITE_ROW+1), range 0..31; c = col-(SPRITE_COL+1+120*b), range 0..39.
- Cell index: cell_row = r[4:3]; cell_col = c/5 (compare chain, no divider).
- Map index = {b[1:0], cell_row[1:0], cell_col[2:0]}.
- FSM states: INIT, IDLE, DECODE, UPDATE.
- Reset value of every output: 0, except busy=1. On reset, health is undefined and the FSM is in INIT.
- INIT: 7-bit counter writes MAX_HEALTH to one cell per cycle over 128 cycles. After writing cell 127: busy<=0, go to IDLE. hit_ready stays 0 throughout.
- IDLE, restore seen: go to INIT with counter=0. Restore takes priority over pending hits.
- IDLE, any hit_valid: round-robin grant and go to DECODE.
  - Both valid: grant the requester not served last. Priority pointer resets to favour req0.
  - hit_ready[g]=1 for exactly that cycle; coordinates latched.
- DECODE: compute in-footprint flag and map index.
- UPDATE: read health, then:
  - Inside footprint and health>0: write health-1, absorbed=1.
  - Otherwise: no write, absorbed=0.
  - Go to IDLE.
- Result timing: accept in cycle T, so resp_valid/resp_id/resp_absorbed are valid in cycle T+3 for one cycle. Next accept is possible at T+3.
- Restore asserted while in DECODE/UPDATE: latched as pending. The in-flight hit completes and responds normally, then the FSM enters INIT.
- Restore asserted during INIT: restarts the counter at 0.
- Pixel query: separate combinational read port, registered output (1-cycle latency).
  - barrier_mask = inside footprint and health>0.
  - Query reads are unaffected by same-cycle writes (old value seen). During INIT, reads return the current array contents.
- Rows/columns outside every footprint (gaps, above, below) give mask=0, health=0.
- Async reset mid-operation: abort any hit with no response, re-enter INIT.

Test Plan:
- Reset release, wait 128 cycles: busy falls on cycle 128. Query (381,41) -> next cycle mask=1, health=3.
- Four req0 hits at (381,41): resp_absorbed=1,1,1,0, each at accept+3. Then query (381,41) gives mask=0. Query (381,46) gives health=3 (neighbour cell untouched).
- Both requesters valid continuously at (400,161) and (400,300): grants alternate 0,1,0,1. resp_id matches. Cell (400,161) in barrier 1 reaches 0 after its three hits.
- Hit at (381,120), gap between barriers 0 and 1: absorbed=0, no cell health changes. Hit at (381,200), last column of barrier 1: absorbed=1.
- Restore one cycle after an accept: response still at accept+3. busy rises the next cycle and stays high 128 cycles. Previously eroded cells read health=3 afterward.
- rst low for one cycle mid-sweep at counter=60: busy=1, outputs 0, sweep restarts. No resp_valid is produced for an aborted in-flight hit.
